// File: rtl/crypt_round_engine_if.sv
// Handshake bundle between the upstream byte source, the round engine and
// the downstream 2:1 output selector (dout -> processed input b,
// raw_out -> bypass input a).
interface crypt_round_engine_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] din;
  logic [7:0] key;
  logic       mode;
  logic [7:0] dout;
  logic [7:0] raw_out;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  // Upstream source / downstream sink side.
  modport master (
    output in_valid, din, key, mode, out_ready,
    input  in_ready, dout, raw_out, out_valid, busy
  );

  // Round engine side.
  modport slave (
    input  in_valid, din, key, mode, out_ready,
    output in_ready, dout, raw_out, out_valid, busy
  );
endinterface

// File: rtl/crypt_round_engine.sv
// Sequential 8-bit iterated block-cipher engine. One byte, key and mode are
// accepted per transaction; ROUNDS invertible rounds run one per clock, and
// the result is held in DONE until the downstream consumer pops it.
module crypt_round_engine #(
  parameter int unsigned ROUNDS = 4,
  parameter logic [7:0]  RC     = 8'h5A
) (
  input  logic                 clk,
  input  logic                 rst,
  crypt_round_engine_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] LAST = 3'(ROUNDS - 1);

  logic [1:0] state_q;
  logic [7:0] x_q;
  logic [7:0] key_q;
  logic       mode_q;
  logic [2:0] cnt_q;
  logic [7:0] raw_q;
  logic [7:0] dout_q;
  logic       in_ready_q;
  logic       out_valid_q;

  logic [7:0] rk;
  logic [7:0] enc_x;
  logic [7:0] dec_x;
  logic [7:0] round_x;
  logic       last_round;

  function automatic logic [7:0] rotl8(input logic [7:0] v, input logic [2:0] n);
    logic [15:0] w;
    w = {v, v} << n;
    return w[15:8];
  endfunction

  function automatic logic [7:0] rotr8(input logic [7:0] v, input logic [2:0] n);
    logic [15:0] w;
    w = {v, v} >> n;
    return w[7:0];
  endfunction

  // Round key and both round directions for the current counter value.
  always_comb begin
    rk         = rotl8(key_q, cnt_q) ^ {5'b0, cnt_q};
    enc_x      = rotl8(x_q ^ rk, 3'd3) + RC;
    dec_x      = rotr8(x_q - RC, 3'd3) ^ rk;
    round_x    = mode_q ? dec_x : enc_x;
    last_round = mode_q ? (cnt_q == 3'd0) : (cnt_q == LAST);
  end

  // Control FSM, datapath and registered handshake decodes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      key_q       <= '0;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      raw_q       <= '0;
      dout_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            x_q        <= bus.din;
            raw_q      <= bus.din;
            key_q      <= bus.key;
            mode_q     <= bus.mode;
            cnt_q      <= bus.mode ? LAST : 3'd0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
          end
        end
        RUN: begin
          x_q   <= round_x;
          // 3-bit counter wraps naturally for ROUNDS = 8.
          cnt_q <= mode_q ? cnt_q - 3'd1 : cnt_q + 3'd1;
          if (last_round) begin
            dout_q      <= round_x;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = ~in_ready_q;
  assign bus.dout      = dout_q;
  assign bus.raw_out   = raw_q;

endmodule

// File: tb/tb_crypt_round_engine.sv
// Scoreboard bench for crypt_round_engine at ROUNDS = 1, 4 and 8.
module tb_crypt_round_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  crypt_round_engine_if b0 ();
  crypt_round_engine_if b1 ();
  crypt_round_engine_if b2 ();

  crypt_round_engine #(.ROUNDS(1), .RC(8'h5A)) u_r1 (.clk(clk), .rst(rst), .bus(b0));
  crypt_round_engine #(.ROUNDS(4), .RC(8'h5A)) u_r4 (.clk(clk), .rst(rst), .bus(b1));
  crypt_round_engine #(.ROUNDS(8), .RC(8'h5A)) u_r8 (.clk(clk), .rst(rst), .bus(b2));

  logic       in_valid_a  [3];
  logic [7:0] din_a       [3];
  logic [7:0] key_a       [3];
  logic       mode_a      [3];
  logic       out_ready_a [3];
  logic       in_ready_a  [3];
  logic       out_valid_a [3];
  logic       busy_a      [3];
  logic [7:0] dout_a      [3];
  logic [7:0] raw_a       [3];

  assign b0.in_valid = in_valid_a[0];  assign b1.in_valid = in_valid_a[1];  assign b2.in_valid = in_valid_a[2];
  assign b0.din      = din_a[0];       assign b1.din      = din_a[1];       assign b2.din      = din_a[2];
  assign b0.key      = key_a[0];       assign b1.key      = key_a[1];       assign b2.key      = key_a[2];
  assign b0.mode     = mode_a[0];      assign b1.mode     = mode_a[1];      assign b2.mode     = mode_a[2];
  assign b0.out_ready = out_ready_a[0]; assign b1.out_ready = out_ready_a[1]; assign b2.out_ready = out_ready_a[2];
  assign in_ready_a[0]  = b0.in_ready;  assign in_ready_a[1]  = b1.in_ready;  assign in_ready_a[2]  = b2.in_ready;
  assign out_valid_a[0] = b0.out_valid; assign out_valid_a[1] = b1.out_valid; assign out_valid_a[2] = b2.out_valid;
  assign busy_a[0]      = b0.busy;      assign busy_a[1]      = b1.busy;      assign busy_a[2]      = b2.busy;
  assign dout_a[0]      = b0.dout;      assign dout_a[1]      = b1.dout;      assign dout_a[2]      = b2.dout;
  assign raw_a[0]       = b0.raw_out;   assign raw_a[1]       = b1.raw_out;   assign raw_a[2]       = b2.raw_out;

  typedef struct {
    logic [7:0] dout;
    logic [7:0] raw;
    int         lat;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rounds_of(input int sel);
    return (sel == 0) ? 1 : (sel == 1) ? 4 : 8;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] v, input int unsigned n);
    logic [7:0] a, b;
    int unsigned m;
    m = n % 8;
    a = v << m;
    b = (m == 0) ? 8'h00 : (v >> (8 - m));
    return a | b;
  endfunction

  function automatic logic [7:0] rr(input logic [7:0] v, input int unsigned n);
    return rl(v, (8 - (n % 8)) % 8);
  endfunction

  function automatic logic [7:0] m_enc(input logic [7:0] p, input logic [7:0] k, input int nr);
    logic [7:0] x, rk;
    x = p;
    for (int r = 0; r < nr; r++) begin
      rk = rl(k, r) ^ 8'(r % 8);
      x  = rl(x ^ rk, 3) + 8'h5A;
    end
    return x;
  endfunction

  function automatic logic [7:0] m_dec(input logic [7:0] c, input logic [7:0] k, input int nr);
    logic [7:0] x, rk;
    x = c;
    for (int r = nr - 1; r >= 0; r--) begin
      rk = rl(k, r) ^ 8'(r % 8);
      x  = rr(x - 8'h5A, 3) ^ rk;
    end
    return x;
  endfunction

  task automatic check_reset_vals(input int sel);
    check("rst_in_ready", in_ready_a[sel], 1);
    check("rst_out_valid", out_valid_a[sel], 0);
    check("rst_busy", busy_a[sel], 0);
    check("rst_dout", dout_a[sel], 0);
    check("rst_raw", raw_a[sel], 0);
  endtask

  // One transaction; with hold set, the result is back-pressured for 10
  // cycles while a stray input pulse is offered.
  task automatic run(input int sel, input logic [7:0] d, input logic [7:0] k,
                     input logic m, input logic [7:0] expv, input bit hold);
    exp_t e;
    int   edges;
    @(negedge clk);
    check("accept_ready", in_ready_a[sel], 1);
    in_valid_a[sel] = 1'b1;
    din_a[sel]      = d;
    key_a[sel]      = k;
    mode_a[sel]     = m;
    e.dout = expv;
    e.raw  = d;
    e.lat  = rounds_of(sel);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    in_valid_a[sel] = 1'b0;
    din_a[sel]      = ~d;
    key_a[sel]      = ~k;
    mode_a[sel]     = ~m;
    edges = 0;
    while (!out_valid_a[sel] && edges < 20) begin
      @(posedge clk);
      edges++;
      #1;
    end
    check("timeout", out_valid_a[sel], 1);
    e = sbq.pop_front();
    check("dout", dout_a[sel], e.dout);
    check("raw_out", raw_a[sel], e.raw);
    check("latency", edges, e.lat);
    if (hold) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        in_valid_a[sel] = (i == 3);
        din_a[sel]      = 8'hC3;
        check("bp_dout", dout_a[sel], e.dout);
        check("bp_valid", out_valid_a[sel], 1);
        check("bp_in_ready", in_ready_a[sel], 0);
      end
      in_valid_a[sel] = 1'b0;
    end
    @(negedge clk);
    out_ready_a[sel] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_a[sel] = 1'b0;
    check("pop_valid", out_valid_a[sel], 0);
    check("pop_in_ready", in_ready_a[sel], 1);
    check("pop_busy", busy_a[sel], 0);
    if (hold) begin
      repeat (3) @(posedge clk);
      #1;
      check("bp_no_txn", out_valid_a[sel], 0);
      check("bp_idle", in_ready_a[sel], 1);
      check("bp_raw_kept", raw_a[sel], e.raw);
    end
  endtask

  initial begin
    logic [7:0] p, k, c;
    for (int i = 0; i < 3; i++) begin
      in_valid_a[i]  = 1'b0;
      din_a[i]       = 8'h00;
      key_a[i]       = 8'h00;
      mode_a[i]      = 1'b0;
      out_ready_a[i] = 1'b0;
    end

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) check_reset_vals(i);

    // Single-round vectors
    run(0, 8'h00, 8'h00, 1'b0, 8'h5A, 1'b0);
    run(0, 8'h0F, 8'hFF, 1'b0, 8'hE1, 1'b0);
    run(0, 8'hE1, 8'hFF, 1'b1, 8'h0F, 1'b0);

    // Round trips at ROUNDS = 4
    for (int i = 0; i < 256; i++) begin
      p = 8'($urandom_range(0, 255));
      k = 8'($urandom_range(0, 255));
      c = m_enc(p, k, 4);
      run(1, p, k, 1'b0, c, 1'b0);
      run(1, c, k, 1'b1, p, 1'b0);
    end
    check("model_roundtrip", m_dec(m_enc(8'h3C, 8'h96, 4), 8'h96, 4), 8'h3C);

    // Back-pressure
    run(1, 8'h5C, 8'h21, 1'b0, m_enc(8'h5C, 8'h21, 4), 1'b1);

    // Reset in the middle of RUN
    @(negedge clk);
    in_valid_a[1] = 1'b1;
    din_a[1]      = 8'h3C;
    key_a[1]      = 8'h11;
    mode_a[1]     = 1'b1;
    @(posedge clk);
    #1;
    in_valid_a[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_busy", busy_a[1], 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_vals(1);
    run(1, 8'hA5, 8'h77, 1'b0, m_enc(8'hA5, 8'h77, 4), 1'b0);
    run(1, 8'hA5, 8'h77, 1'b1, m_dec(8'hA5, 8'h77, 4), 1'b0);

    // Wrap and constant edges at ROUNDS = 8
    c = m_enc(8'hFF, 8'h80, 8);
    run(2, 8'hFF, 8'h80, 1'b0, c, 1'b0);
    run(2, c, 8'h80, 1'b1, 8'hFF, 1'b0);

    check("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
